// File: rtl/dispatch_lane_sequencer.sv
// ----------------------------------------------------------------------------
// dispatch_lane_sequencer
//
// Purpose:
//   Takes one full-warp instruction packet (NUM_THREADS lanes) from a dispatch
//   buffer and replays it as NUM_LANES-wide sub-packets to a narrower execution
//   unit. Lane groups whose thread-mask slice is all zero are skipped. Each
//   sub-packet carries its lane-group index (pid) and sop/eop markers so the
//   writeback side can reassemble the warp.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   in_valid/in_ready upstream handshake for one full-warp packet
//   in_tmask          thread mask, one bit per lane
//   in_rs1..in_rs3    operands, lane i at [i*XLEN +: XLEN]
//   in_meta           opaque sideband, passed through untouched
//   out_valid/ready   downstream handshake for one sub-packet
//   out_tmask         mask slice of the current lane group
//   out_rs1..out_rs3  operand slices of the current lane group
//   out_meta          held sideband of the current instruction
//   out_pid           index of the current lane group
//   out_sop/out_eop   first / last emitted sub-packet of the instruction
// ----------------------------------------------------------------------------
module dispatch_lane_sequencer #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int META_W      = 64,
  localparam int NUM_PKTS   = NUM_THREADS / NUM_LANES,
  localparam int PID_W      = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_THREADS-1:0]      in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs1,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs2,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs3,
  input  logic [META_W-1:0]           in_meta,

  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES-1:0]        out_tmask,
  output logic [NUM_LANES*XLEN-1:0]   out_rs1,
  output logic [NUM_LANES*XLEN-1:0]   out_rs2,
  output logic [NUM_LANES*XLEN-1:0]   out_rs3,
  output logic [META_W-1:0]           out_meta,
  output logic [PID_W-1:0]            out_pid,
  output logic                        out_sop,
  output logic                        out_eop
);

  localparam int GW = NUM_LANES * XLEN;

  // Holding register for the instruction being sequenced (not reset: its
  // contents are only observed while full_q is set).
  logic [NUM_THREADS-1:0]      tmask_q;
  logic [NUM_THREADS*XLEN-1:0] rs1_q, rs2_q, rs3_q;
  logic [META_W-1:0]           meta_q;

  logic                        full_q, full_d;
  logic [PID_W-1:0]            cur_q, cur_d;
  logic                        sop_q, sop_d;

  logic                        in_fire, out_fire;

  // Per-group helper vectors.
  logic [PID_W-1:0]            grp_id [NUM_PKTS];
  logic [NUM_PKTS-1:0]         grp_sel;   // group equals cursor
  logic [NUM_PKTS-1:0]         grp_later; // group index above cursor
  logic [NUM_PKTS-1:0]         nz_hold;   // held mask slice non-zero
  logic [NUM_PKTS-1:0]         nz_in;     // incoming mask slice non-zero
  logic [NUM_PKTS-1:0]         next_cand;

  logic [PID_W-1:0]            next_grp;
  logic [PID_W-1:0]            first_grp;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PKTS; gi++) begin : g_grp
      assign grp_id[gi]    = PID_W'(gi);
      assign grp_sel[gi]   = (cur_q == PID_W'(gi));
      assign grp_later[gi] = (cur_q <  PID_W'(gi));
      assign nz_hold[gi]   = |tmask_q[gi*NUM_LANES +: NUM_LANES];
      assign nz_in[gi]     = |in_tmask[gi*NUM_LANES +: NUM_LANES];
    end
  endgenerate

  assign next_cand = nz_hold & grp_later;

  // Priority encoders: scanning downward leaves the lowest hit in the result.
  always_comb begin
    next_grp  = cur_q;
    first_grp = '0;
    for (int g = NUM_PKTS - 1; g >= 0; g--) begin
      if (next_cand[g]) next_grp  = grp_id[g];
      if (nz_in[g])     first_grp = grp_id[g];
    end
  end

  // Output slice mux driven by the cursor.
  always_comb begin
    out_tmask = '0;
    out_rs1   = '0;
    out_rs2   = '0;
    out_rs3   = '0;
    for (int g = 0; g < NUM_PKTS; g++) begin
      if (grp_sel[g]) begin
        out_tmask = tmask_q[g*NUM_LANES +: NUM_LANES];
        out_rs1   = rs1_q[g*GW +: GW];
        out_rs2   = rs2_q[g*GW +: GW];
        out_rs3   = rs3_q[g*GW +: GW];
      end
    end
  end

  assign out_valid = full_q;
  assign out_meta  = meta_q;
  assign out_pid   = cur_q;
  assign out_sop   = sop_q;
  // Last sub-packet when no active group remains above the cursor.
  assign out_eop   = ~|next_cand;

  // Refill in the same cycle the last sub-packet leaves: no bubble between
  // instructions. This is the only path from out_ready to in_ready.
  assign in_ready  = !full_q || (out_ready && out_eop);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = full_q && out_ready;

  always_comb begin
    full_d = full_q;
    cur_d  = cur_q;
    sop_d  = sop_q;
    if (out_fire) begin
      if (!out_eop) begin
        cur_d = next_grp;
        sop_d = 1'b0;
      end else begin
        full_d = 1'b0;
      end
    end
    // A new load overrides the drain of the previous instruction's last beat.
    if (in_fire) begin
      full_d = 1'b1;
      sop_d  = 1'b1;
      cur_d  = first_grp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      cur_q  <= '0;
      sop_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      cur_q  <= cur_d;
      sop_q  <= sop_d;
    end
  end

  // Data path load; a load during reset is harmless because full_q is cleared.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      tmask_q <= in_tmask;
      rs1_q   <= in_rs1;
      rs2_q   <= in_rs2;
      rs3_q   <= in_rs3;
      meta_q  <= in_meta;
    end
  end

endmodule

// File: doc/dispatch_lane_sequencer.md
Name: dispatch_lane_sequencer

Overview:
- Sits directly downstream of one per-EX-unit dispatch buffer output.
- Accepts one full-warp instruction packet of NUM_THREADS lanes and emits it as a sequence of NUM_LANES-wide sub-packets to an execution unit narrower than the warp.
- Skips lane groups whose thread mask is all zero.
- Tags each sub-packet with packet id (pid), start-of-packet (sop) and end-of-packet (eop) for writeback reassembly.

Parameters:
- NUM_THREADS, 4, warp width in lanes; must be a multiple of NUM_LANES.
- NUM_LANES, 2, execution-unit lane width.
- XLEN, 32, operand width per lane.
- META_W, 64, opaque per-instruction sideband (uuid, wis, PC, op_type, op_args, wb, rd, tid); passed through unmodified.
- NUM_PKTS, NUM_THREADS/NUM_LANES, derived; number of lane groups.
- PID_W, max(1, clog2(NUM_PKTS)), derived.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream packet valid
- in_ready  out  1  upstream packet accepted when in_valid && in_ready
- in_tmask  in  NUM_THREADS  thread mask
- in_rs1  in  NUM_THREADS*XLEN  operand 1, lane i at bits [i*XLEN +: XLEN]
- in_rs2  in  NUM_THREADS*XLEN  operand 2
- in_rs3  in  NUM_THREADS*XLEN  operand 3
- in_meta  in  META_W  sideband
- out_valid  out  1  sub-packet valid
- out_ready  in  1  downstream accept
- out_tmask  out  NUM_LANES  thread-mask slice for the current group
- out_rs1  out  NUM_LANES*XLEN  operand-1 slice
- out_rs2  out  NUM_LANES*XLEN  operand-2 slice
- out_rs3  out  NUM_LANES*XLEN  operand-3 slice
- out_meta  out  META_W  held sideband
- out_pid  out  PID_W  lane-group index of the current sub-packet
- out_sop  out  1  first emitted sub-packet of the instruction
- out_eop  out  1  last emitted sub-packet of the instruction

Behaviour:
- State: holding register H (tmask, rs1-3, meta), full flag F, cursor C (PID_W), sop flag S.
- out_valid = F.
- Output slices are a combinational mux of H at group C. Group g covers lanes [g*NUM_LANES +: NUM_LANES].
- out_meta = H.meta; out_pid = C; out_sop = S.
- nz(g) = |H.tmask slice g.
- out_eop = 1 when no g > C has nz(g).
- in_ready = !F || (out_valid && out_ready && out_eop). This allows back-to-back instructions with no bubble.
- Input fire:
  - H <= inputs; F <= 1; S <= 1.
  - C <= lowest g with a nonzero slice of in_tmask, or 0 if in_tmask == 0.
  - Latency: first sub-packet is valid the cycle after input fire.
- Output fire with !out_eop: C <= lowest g > C with nz(g); S <= 0.
- Output fire with out_eop and no simultaneous input fire: F <= 0.
- Output fire with out_eop and simultaneous input fire: the input-fire load takes effect; F stays 1.
- All-zero tmask: exactly one sub-packet with pid 0, tmask 0, sop = 1, eop = 1.
- NUM_PKTS == 1: pid is always 0, sop = eop = 1; the block acts as a one-entry register stage.
- Backpressure: while out_valid && !out_ready, all out_* signals hold stable and C does not advance.
- Throughput: k nonzero groups give k output cycles per instruction, with no idle cycles between groups.
- Reset: F = 0, C = 0, S = 0, so out_valid = 0.
  - H is not reset; out data is don't-care while out_valid = 0.
  - in_ready = 1 on the cycle after reset deasserts.
- Reset mid-instruction: the remaining sub-packets are dropped, no partial emission occurs after reset, and an input presented during reset is not captured.
- No combinational path from in_valid to out_valid.
- in_ready depends combinationally on out_ready.

Test Plan:
(all with NUM_THREADS=4, NUM_LANES=2, XLEN=32)
1. tmask=1111, rs1={D,C,B,A} (lane3..0), out_ready=1 -> cycle+1: pid0, tmask 11, rs1={B,A}, sop1 eop0; cycle+2: pid1, tmask 11, rs1={D,C}, sop0 eop1.
2. tmask=1100 -> exactly one sub-packet: pid1, tmask 11, sop1 eop1; in_ready=1 in that cycle.
3. tmask=0000, meta=0x1234 -> one sub-packet: pid0, tmask 00, sop1 eop1, meta 0x1234.
4. Two full-mask instructions presented back-to-back, out_ready=1 -> 4 consecutive out_valid cycles with pids 0,1,0,1; second instruction accepted in the cycle of the first eop.
5. tmask=1111, out_ready=0 for 3 cycles after the first sub-packet is valid -> pid0 data stable, in_ready=0; with out_ready=1 the sequence completes normally.
6. Assert reset while pid0 of a full-mask instruction is pending -> out_valid=0 the next cycle, pid1 is never emitted, and a fresh instruction afterwards starts at sop=1.
